// File: rtl/reorder_buffer_pkg.sv
// Shared CPU widths and codes used by the ROB, the register file and the dispatcher.
// The entry record below is the layout of one ROB slot.
package reorder_buffer_pkg;

  localparam int                ROB_WIDTH_DEF = 3;
  localparam int                REG_W         = 5;
  localparam int                UPD_REG_W     = 6;
  localparam int                DATA_W        = 32;
  localparam int                PC_W          = 32;
  localparam logic [UPD_REG_W-1:0] NON_DEP_CODE = 6'b100000;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  rd;
    logic              is_branch;
    logic              pred_taken;
    logic              taken;
    logic [PC_W-1:0]   alt_pc;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, result-broadcast and commit/flush bundle between the ROB and the core.
// slave is the ROB side; master is the dispatcher/CDB/register-file side.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int RoB_WIDTH = ROB_WIDTH_DEF
);

  logic                 issue_en;
  logic [REG_W-1:0]     issue_rd;
  logic                 issue_is_branch;
  logic                 issue_pred_taken;
  logic [PC_W-1:0]      issue_alt_pc;
  logic                 rob_full;
  logic [RoB_WIDTH-1:0] issue_index;

  logic                 cdb_en;
  logic [RoB_WIDTH-1:0] cdb_index;
  logic [DATA_W-1:0]    cdb_data;
  logic                 cdb_taken;

  logic                 RoB_update_en;
  logic [UPD_REG_W-1:0] RoB_update_reg;
  logic [RoB_WIDTH-1:0] RoB_update_index;
  logic [DATA_W-1:0]    RoB_update_data;

  logic                 flush_signal;
  logic [PC_W-1:0]      flush_pc;

  modport slave (
    input  issue_en, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  cdb_en, cdb_index, cdb_data, cdb_taken,
    output rob_full, issue_index,
    output RoB_update_en, RoB_update_reg, RoB_update_index, RoB_update_data,
    output flush_signal, flush_pc
  );

  modport master (
    output issue_en, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output cdb_en, cdb_index, cdb_data, cdb_taken,
    input  rob_full, issue_index,
    input  RoB_update_en, RoB_update_reg, RoB_update_index, RoB_update_data,
    input  flush_signal, flush_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit buffer: issue at tail, CDB results fill entries, head commits combinationally.
// One-cycle result-to-commit latency; issue stalls while full; rdy_in low freezes everything.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int                    RoB_WIDTH = ROB_WIDTH_DEF,
  parameter logic [UPD_REG_W-1:0]  NON_DEP   = NON_DEP_CODE
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  reorder_buffer_if.slave   rob_bus
);

  localparam int                 DEPTH    = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] FULL_CNT = (RoB_WIDTH + 1)'(DEPTH);

  rob_entry_t           entries [DEPTH];
  rob_entry_t           head_e;
  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;

  logic commit_ok;
  logic mispredict;
  logic do_issue;
  logic cdb_hit;

  assign head_e     = entries[head];
  assign commit_ok  = rdy_in && head_e.busy && head_e.ready;
  assign mispredict = commit_ok && head_e.is_branch && (head_e.taken != head_e.pred_taken);

  // Full is judged on registered count, so a commit never frees a slot for the same cycle.
  assign rob_bus.rob_full    = (count == FULL_CNT);
  assign rob_bus.issue_index = tail;

  assign do_issue = rdy_in && rob_bus.issue_en && !rob_bus.rob_full && !mispredict;
  assign cdb_hit  = rob_bus.cdb_en && entries[rob_bus.cdb_index].busy
                    && !entries[rob_bus.cdb_index].ready;

  assign rob_bus.RoB_update_en    = commit_ok && !mispredict;
  assign rob_bus.RoB_update_index = head;
  assign rob_bus.RoB_update_data  = head_e.data;
  assign rob_bus.RoB_update_reg   = (!head_e.is_branch && (head_e.rd != '0))
                                    ? {1'b0, head_e.rd} : NON_DEP;

  assign rob_bus.flush_signal = mispredict;
  assign rob_bus.flush_pc     = mispredict ? head_e.alt_pc : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (rdy_in) begin
      if (mispredict) begin
        // Everything younger than the branch is wrong-path; drop it all.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          entries[i].busy <= 1'b0;
        end
      end else begin
        if (cdb_hit) begin
          entries[rob_bus.cdb_index].data  <= rob_bus.cdb_data;
          entries[rob_bus.cdb_index].taken <= rob_bus.cdb_taken;
          entries[rob_bus.cdb_index].ready <= 1'b1;
        end

        if (do_issue) begin
          entries[tail] <= '{busy:       1'b1,
                             ready:      1'b0,
                             rd:         rob_bus.issue_rd,
                             is_branch:  rob_bus.issue_is_branch,
                             pred_taken: rob_bus.issue_pred_taken,
                             taken:      1'b0,
                             alt_pc:     rob_bus.issue_alt_pc,
                             data:       '0};
          tail <= tail + 1'b1;
        end

        if (commit_ok) begin
          entries[head].busy <= 1'b0;
          head               <= head + 1'b1;
        end

        case ({do_issue, commit_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue/complete/commit ordering, full, flush, pause, reset.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_cmp = 0;
  int   n_bad = 0;

  reorder_buffer_if rif ();

  reorder_buffer dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .rdy_in  (rdy),
    .rob_bus (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    rif.issue_en         = 1'b0;
    rif.issue_rd         = '0;
    rif.issue_is_branch  = 1'b0;
    rif.issue_pred_taken = 1'b0;
    rif.issue_alt_pc     = '0;
    rif.cdb_en           = 1'b0;
    rif.cdb_index        = '0;
    rif.cdb_data         = '0;
    rif.cdb_taken        = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic pred,
                       input logic [31:0] alt);
    rif.issue_en         = 1'b1;
    rif.issue_rd         = rd;
    rif.issue_is_branch  = br;
    rif.issue_pred_taken = pred;
    rif.issue_alt_pc     = alt;
  endtask

  task automatic cdb(input logic [2:0] idx, input logic [31:0] data, input logic taken);
    rif.cdb_en    = 1'b1;
    rif.cdb_index = idx;
    rif.cdb_data  = data;
    rif.cdb_taken = taken;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_full",    rif.rob_full,       0);
    chk("rst_idx",     rif.issue_index,    0);
    chk("rst_upd_en",  rif.RoB_update_en,  0);
    chk("rst_upd_reg", rif.RoB_update_reg, 6'h20);
    chk("rst_flush",   rif.flush_signal,   0);
    chk("rst_fpc",     rif.flush_pc,       0);

    // single issue -> result -> commit
    idle(); issue(5'd5, 0, 0, 0); settle();
    chk("s1_idx0", rif.issue_index, 0);
    tick();
    idle(); settle();
    chk("s1_idx1",  rif.issue_index,   1);
    chk("s1_cnt1",  dut.count,         1);
    chk("s1_noupd", rif.RoB_update_en, 0);
    cdb(3'd0, 32'h1234, 0);
    tick();
    idle(); settle();
    chk("s1_upd_en",  rif.RoB_update_en,    1);
    chk("s1_upd_reg", rif.RoB_update_reg,   6'd5);
    chk("s1_upd_idx", rif.RoB_update_index, 0);
    chk("s1_upd_dat", rif.RoB_update_data,  32'h1234);
    tick();
    idle(); settle();
    chk("s1_cnt0",  rif.RoB_update_en, 0);
    chk("s1_cnt0b", dut.count,         0);

    // fill to capacity, ignore the 9th, free one slot via commit
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); issue(5'(i + 1), 0, 0, 0); tick();
    end
    idle(); settle();
    chk("s2_full", rif.rob_full,    1);
    chk("s2_idx",  rif.issue_index, 0);
    issue(5'd9, 0, 0, 0);
    tick();
    idle(); settle();
    chk("s2_9th_idx", rif.issue_index, 0);
    chk("s2_9th_cnt", dut.count,       8);
    cdb(3'd0, 32'hA0, 0);
    tick();
    idle(); issue(5'd3, 0, 0, 0); settle();
    chk("s2_cm_en",   rif.RoB_update_en,   1);
    chk("s2_cm_dat",  rif.RoB_update_data, 32'hA0);
    chk("s2_cm_full", rif.rob_full,        1);
    tick();
    idle(); settle();
    chk("s2_post_idx",  rif.issue_index, 0);
    chk("s2_post_cnt",  dut.count,       7);
    chk("s2_post_full", rif.rob_full,    0);

    // out-of-order completion, in-order commit
    do_reset();
    idle(); issue(5'd1, 0, 0, 0); tick();
    idle(); issue(5'd2, 0, 0, 0); tick();
    idle(); issue(5'd3, 0, 0, 0); tick();
    idle(); cdb(3'd2, 32'h22, 0); settle(); chk("s3_w2", rif.RoB_update_en, 0); tick();
    idle(); cdb(3'd1, 32'h11, 0); settle(); chk("s3_w1", rif.RoB_update_en, 0); tick();
    idle(); cdb(3'd0, 32'h10, 0); settle(); chk("s3_w0", rif.RoB_update_en, 0); tick();
    idle(); settle();
    chk("s3_c0_en",  rif.RoB_update_en,    1);
    chk("s3_c0_idx", rif.RoB_update_index, 0);
    chk("s3_c0_dat", rif.RoB_update_data,  32'h10);
    chk("s3_c0_reg", rif.RoB_update_reg,   6'd1);
    tick(); settle();
    chk("s3_c1_idx", rif.RoB_update_index, 1);
    chk("s3_c1_dat", rif.RoB_update_data,  32'h11);
    chk("s3_c1_reg", rif.RoB_update_reg,   6'd2);
    tick(); settle();
    chk("s3_c2_idx", rif.RoB_update_index, 2);
    chk("s3_c2_dat", rif.RoB_update_data,  32'h22);
    chk("s3_c2_en",  rif.RoB_update_en,    1);
    tick(); settle();
    chk("s3_done_en",  rif.RoB_update_en, 0);
    chk("s3_done_cnt", dut.count,         0);

    // mispredicted branch with two younger entries
    do_reset();
    idle(); issue(5'd0, 1, 0, 32'h80); tick();
    idle(); issue(5'd7, 0, 0, 0); tick();
    idle(); issue(5'd8, 0, 0, 0); tick();
    idle(); cdb(3'd0, 32'h0, 1); settle();
    chk("s4_pre_flush", rif.flush_signal, 0);
    tick();
    idle(); issue(5'd9, 0, 0, 0); cdb(3'd1, 32'h55, 0); settle();
    chk("s4_flush",   rif.flush_signal,   1);
    chk("s4_fpc",     rif.flush_pc,       32'h80);
    chk("s4_upd_en",  rif.RoB_update_en,  0);
    chk("s4_upd_reg", rif.RoB_update_reg, 6'h20);
    tick();
    idle(); settle();
    chk("s4_cnt",    dut.count,        0);
    chk("s4_head",   dut.head,         0);
    chk("s4_tail",   rif.issue_index,  0);
    chk("s4_flush0", rif.flush_signal, 0);
    chk("s4_fpc0",   rif.flush_pc,     0);

    // correctly predicted branch commits without a register write target
    idle(); issue(5'd0, 1, 1, 32'h100); tick();
    idle(); cdb(3'd0, 32'h7, 1); tick();
    idle(); settle();
    chk("s4b_en",    rif.RoB_update_en,  1);
    chk("s4b_reg",   rif.RoB_update_reg, 6'h20);
    chk("s4b_flush", rif.flush_signal,   0);
    chk("s4b_fpc",   rif.flush_pc,       0);
    tick();

    // pause holds a ready head for three cycles
    do_reset();
    idle(); issue(5'd4, 0, 0, 0); tick();
    idle(); cdb(3'd0, 32'h44, 0); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; issue(5'd6, 0, 0, 0); settle();
      chk("s5_pause_en", rif.RoB_update_en, 0);
      tick();
      settle();
      chk("s5_pause_cnt", dut.count,       1);
      chk("s5_pause_idx", rif.issue_index, 1);
    end
    idle(); rdy = 1'b1; settle();
    chk("s5_go_en",  rif.RoB_update_en,   1);
    chk("s5_go_dat", rif.RoB_update_data, 32'h44);
    tick(); settle();
    chk("s5_go_cnt", dut.count, 0);

    // reset with four entries in flight, rdy_in low
    for (int i = 0; i < 4; i++) begin
      idle(); issue(5'(i + 10), 0, 0, 0); tick();
    end
    idle(); settle();
    chk("s6_pre_cnt", dut.count, 4);
    rdy = 1'b0; rst = 1'b1; issue(5'd9, 0, 0, 0); cdb(3'd1, 32'h99, 0);
    tick();
    rst = 1'b0; rdy = 1'b1; idle(); settle();
    chk("s6_full",    rif.rob_full,       0);
    chk("s6_idx",     rif.issue_index,    0);
    chk("s6_upd_en",  rif.RoB_update_en,  0);
    chk("s6_upd_reg", rif.RoB_update_reg, 6'h20);
    chk("s6_flush",   rif.flush_signal,   0);
    chk("s6_fpc",     rif.flush_pc,       0);
    chk("s6_cnt",     dut.count,          0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 3, log2 of entry count (8 entries).
REQ-002 SHALL have parameter NON_DEP, default 6'b100000, "no destination register" code on the commit port.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  global run enable; low means pause.
REQ-006 SHALL have ports issue_en, issue_rd[4:0], issue_is_branch, issue_pred_taken  input  1/5/1/1  dispatch request, destination reg, branch flag, predicted direction.
REQ-007 SHALL have port issue_alt_pc  input  32  redirect PC used if the branch mispredicts.
REQ-008 SHALL have ports rob_full  output  1 and issue_index  output  RoB_WIDTH; issue_index is the current tail.
REQ-009 SHALL have ports cdb_en, cdb_index[RoB_WIDTH-1:0], cdb_data[31:0], cdb_taken  input  result broadcast: entry, value, actual branch direction.
REQ-010 SHALL have ports RoB_update_en 1, RoB_update_reg 6, RoB_update_index RoB_WIDTH, RoB_update_data 32  output  in-order commit to the register file.
REQ-011 SHALL have ports flush_signal 1, flush_pc 32  output  misprediction flush and redirect target.

Function
REQ-012 SHALL hold a circular buffer of 2^RoB_WIDTH entries (busy, ready, rd, is_branch, pred_taken, taken, alt_pc, data), with head, tail and count registers.
REQ-013 SHALL drive rob_full = (count == 2^RoB_WIDTH) from registered count only; a same-cycle commit does not free a slot for a same-cycle issue.
REQ-014 SHALL, on issue_en && !rob_full && rdy_in && !flush_signal, write the tail entry (busy=1, ready=0), advance tail modulo 2^RoB_WIDTH, and increment count; issue_en while full is ignored.
REQ-015 SHALL, on cdb_en to a busy, not-ready entry, store cdb_data and cdb_taken and set ready; cdb_en to a non-busy or already-ready entry is ignored.
REQ-016 SHALL define commit_ok = rdy_in && head busy && head ready, and mispredict = commit_ok && is_branch && (taken != pred_taken).
REQ-017 SHALL drive commit outputs combinationally from the head entry: RoB_update_en = commit_ok && !mispredict; RoB_update_index = head; RoB_update_data = data.
REQ-018 SHALL drive RoB_update_reg = {1'b0, rd} for non-branch entries with rd != 0, else NON_DEP.
REQ-019 SHALL drive flush_signal = mispredict and flush_pc = head alt_pc (0 when not flushing).
REQ-020 SHALL, on a non-flush commit edge, clear the head entry busy bit, advance head and decrement count; simultaneous issue+commit leaves count unchanged.
REQ-021 SHALL, on the flush edge, clear all busy bits and set head=tail=count=0, ignoring same-cycle issue and cdb.
REQ-022 SHALL have one-cycle latency: a CDB write at edge N makes the entry committable during cycle N+1 if it is at the head.
REQ-023 SHALL, while rdy_in is low, hold all state and keep RoB_update_en and flush_signal at 0.
REQ-024 SHALL commit at most one entry per cycle.

Reset
REQ-025 SHALL, on rst_in high at a clock edge, clear all busy/ready bits and set head, tail and count to 0; reset dominates rdy_in and all other inputs.
REQ-026 SHALL produce, after reset, rob_full=0, issue_index=0, RoB_update_en=0, RoB_update_reg=NON_DEP, flush_signal=0 and flush_pc=0.

Structure
REQ-027 SHALL take RoB_WIDTH, NON_DEP and the entry field widths from the shared CPU package also used by the register file and dispatcher.
REQ-028 SHALL be a single module with no sub-module; the entry array is a flat register array.

Verification
REQ-029 SHALL pass this scenario: issue rd=5 at index 0, then cdb index 0 data 0x1234 -> next cycle RoB_update_en=1, reg=6'd5, index=0, data=0x1234; count returns to 0.
REQ-030 SHALL pass this scenario: issue 8 entries -> rob_full=1; a 9th issue is ignored (tail stays 0); complete entry 0 -> rob_full=0 one edge after commit.
REQ-031 SHALL pass this scenario: results for indices 2,1,0 arrive out of order -> commits occur in order 0,1,2 on consecutive cycles.
REQ-032 SHALL pass this scenario: branch pred_taken=0, alt_pc=0x80, cdb_taken=1, two younger entries pending -> flush_signal=1, flush_pc=0x80, RoB_update_en=0; next cycle count=0, head=tail=0.
REQ-033 SHALL pass this scenario: head ready while rdy_in=0 for 3 cycles -> no commit; commit occurs in the first cycle rdy_in=1.
REQ-034 SHALL pass this scenario: rst_in asserted with 4 entries busy -> next cycle all outputs at reset values, and issue_index=0.
